// File: rtl/fxp_mul16_seq.sv
// Sequential signed fixed-point multiplier: one shift-add partial product per clock,
// then round (half away from zero, on the magnitude) and saturate to WIDTH bits.
// Start/done handshake; result and sat hold between done pulses.
module fxp_mul16_seq #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned FRAC_BITS = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             done,
  output logic             busy,
  output logic             sat
);

  localparam int unsigned AW = 2 * WIDTH;
  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] MUL   = 3'd1;
  localparam logic [2:0] ROUND = 3'd2;
  localparam logic [2:0] SAT   = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  // Rounding increment and clamp limits, all at the widened magnitude width.
  localparam logic [AW:0] HALF    = {{AW{1'b0}}, 1'b1} << (FRAC_BITS - 1);
  localparam logic [AW:0] POS_LIM = {{(AW + 2 - WIDTH){1'b0}}, {(WIDTH - 1){1'b1}}};
  localparam logic [AW:0] NEG_LIM = {{(AW + 1 - WIDTH){1'b0}}, 1'b1, {(WIDTH - 1){1'b0}}};

  localparam logic [WIDTH-1:0] RES_POS = {1'b0, {(WIDTH - 1){1'b1}}};
  localparam logic [WIDTH-1:0] RES_NEG = {1'b1, {(WIDTH - 1){1'b0}}};

  logic [2:0]       state_q, state_d;
  logic [AW-1:0]    mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             sign_q, sign_d;
  logic [AW:0]      mag_q, mag_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             sat_q, sat_d;

  logic [WIDTH-1:0] abs_a, abs_b;

  // Operand magnitudes; the most negative value maps to 2^(WIDTH-1) as an unsigned number.
  always_comb begin
    abs_a = a[WIDTH-1] ? (~a + WIDTH'(1)) : a;
    abs_b = b[WIDTH-1] ? (~b + WIDTH'(1)) : b;
  end

  // Next-state and datapath control.
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    sign_d   = sign_q;
    mag_d    = mag_q;
    result_d = result_q;
    sat_d    = sat_q;

    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          mcand_d  = {{WIDTH{1'b0}}, abs_a};
          mplier_d = abs_b;
          sign_d   = a[WIDTH-1] ^ b[WIDTH-1];
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = MUL;
        end
      end
      MUL: begin
        if (mplier_q[0]) begin
          acc_d = acc_q + mcand_q;
        end
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = ROUND;
        end
      end
      ROUND: begin
        // One extra bit of headroom so the rounding add cannot overflow.
        mag_d   = ({1'b0, acc_q} + HALF) >> FRAC_BITS;
        state_d = SAT;
      end
      SAT: begin
        if (!sign_q && (mag_q > POS_LIM)) begin
          result_d = RES_POS;
          sat_d    = 1'b1;
        end else if (sign_q && (mag_q > NEG_LIM)) begin
          result_d = RES_NEG;
          sat_d    = 1'b1;
        end else begin
          // Negating a zero magnitude yields +0, so no special case is needed.
          result_d = sign_q ? -mag_q[WIDTH-1:0] : mag_q[WIDTH-1:0];
          sat_d    = 1'b0;
        end
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      sign_q   <= 1'b0;
      mag_q    <= '0;
      result_q <= '0;
      sat_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      sign_q   <= sign_d;
      mag_q    <= mag_d;
      result_q <= result_d;
      sat_q    <= sat_d;
    end
  end

  // Status outputs decoded from the state register.
  always_comb begin
    done   = (state_q == DONE);
    busy   = (state_q == MUL) || (state_q == ROUND) || (state_q == SAT);
    result = result_q;
    sat    = sat_q;
  end

endmodule

// File: tb/tb_fxp_mul16_seq.sv
// Directed and random checks of the sequential Q8.8 multiplier.
module tb_fxp_mul16_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] a, b;
  logic [15:0] result;
  logic        done, busy, sat;

  int n_checks = 0;
  int n_fail   = 0;

  fxp_mul16_seq #(
    .WIDTH    (16),
    .FRAC_BITS(8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .a     (a),
    .b     (b),
    .result(result),
    .done  (done),
    .busy  (busy),
    .sat   (sat)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Launch one operation and wait (bounded) for done; edges counted from the sampling edge.
  task automatic run_op(input logic [15:0] ia, input logic [15:0] ib, output int edges,
                        output logic b0, output logic bprev, output logic bdone);
    a     = ia;
    b     = ib;
    start = 1'b1;
    step();
    start = 1'b0;
    b0    = busy;
    bprev = busy;
    edges = 0;
    while (!done && edges < 100) begin
      bprev = busy;
      step();
      edges++;
    end
    bdone = busy;
  endtask

  // Reference: round half away from zero of a*b/256, clamped to 16-bit signed.
  task automatic ref_mul(input logic [15:0] x, input logic [15:0] y,
                         output logic [15:0] r, output logic s);
    longint p, m, q;
    p = longint'($signed(x)) * longint'($signed(y));
    m = (p < 0) ? -p : p;
    q = (m + 128) >>> 8;
    if (p < 0) q = -q;
    if (q > 32767) begin
      r = 16'h7FFF;
      s = 1'b1;
    end else if (q < -32768) begin
      r = 16'h8000;
      s = 1'b1;
    end else begin
      r = q[15:0];
      s = 1'b0;
    end
  endtask

  initial begin
    int          edges, n2, dones;
    logic        b0, bprev, bdone;
    logic [15:0] er, ra, rb;
    logic        es;

    reset = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    step();
    step();
    check("rst_done", 32'(done), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_result", 32'(result), 32'h0);
    check("rst_sat", 32'(sat), 32'h0);
    reset = 1'b0;
    step();

    // 1.5 * 2.0
    run_op(16'h0180, 16'h0200, edges, b0, bprev, bdone);
    check("t1_latency", 32'(edges), 32'd18);
    check("t1_result", 32'(result), 32'h0300);
    check("t1_sat", 32'(sat), 32'h0);
    check("t1_busy_first", 32'(b0), 32'h1);
    check("t1_busy_last", 32'(bprev), 32'h1);
    check("t1_busy_at_done", 32'(bdone), 32'h0);
    step();
    check("t1_done_pulse", 32'(done), 32'h0);
    check("t1_result_hold", 32'(result), 32'h0300);

    // Signs and rounding
    run_op(16'hFE80, 16'h0200, edges, b0, bprev, bdone);
    check("t2_neg_result", 32'(result), 32'hFD00);
    check("t2_neg_sat", 32'(sat), 32'h0);
    run_op(16'h0001, 16'h0080, edges, b0, bprev, bdone);
    check("t2_half_up", 32'(result), 32'h0001);
    run_op(16'hFFFF, 16'h0080, edges, b0, bprev, bdone);
    check("t2_half_away", 32'(result), 32'hFFFF);
    check("t2_half_away_sat", 32'(sat), 32'h0);

    // Saturation
    run_op(16'h7FFF, 16'h7FFF, edges, b0, bprev, bdone);
    check("t3_pos_sat_res", 32'(result), 32'h7FFF);
    check("t3_pos_sat_flag", 32'(sat), 32'h1);
    run_op(16'h8000, 16'h8000, edges, b0, bprev, bdone);
    check("t3_minmin_res", 32'(result), 32'h7FFF);
    check("t3_minmin_flag", 32'(sat), 32'h1);
    run_op(16'h8000, 16'h0100, edges, b0, bprev, bdone);
    check("t3_neg_edge_res", 32'(result), 32'h8000);
    check("t3_neg_edge_flag", 32'(sat), 32'h0);
    run_op(16'h0000, 16'h8000, edges, b0, bprev, bdone);
    check("t3_zero_res", 32'(result), 32'h0000);
    check("t3_zero_flag", 32'(sat), 32'h0);
    step();

    // Start pulsed during MUL is ignored
    a     = 16'h0180;
    b     = 16'h0200;
    start = 1'b1;
    step();
    start = 1'b0;
    edges = 0;
    repeat (3) begin
      step();
      edges++;
    end
    a     = 16'h7FFF;
    b     = 16'h7FFF;
    start = 1'b1;
    step();
    edges++;
    start = 1'b0;
    while (!done && edges < 100) begin
      step();
      edges++;
    end
    check("t4a_latency", 32'(edges), 32'd18);
    check("t4a_result", 32'(result), 32'h0300);
    check("t4a_sat", 32'(sat), 32'h0);
    step();
    check("t4a_no_second_done", 32'(busy), 32'h0);

    // Start held high across DONE: back-to-back, operands changed after capture
    a     = 16'h0180;
    b     = 16'h0200;
    start = 1'b1;
    step();
    a     = 16'h0100;
    b     = 16'h0280;
    edges = 0;
    while (!done && edges < 100) begin
      step();
      edges++;
    end
    check("t4b_first_latency", 32'(edges), 32'd18);
    check("t4b_first_result", 32'(result), 32'h0300);
    step();
    start = 1'b0;
    n2    = 1;
    while (!done && n2 < 100) begin
      step();
      n2++;
    end
    check("t4b_gap", 32'(n2), 32'd19);
    check("t4b_second_result", 32'(result), 32'h0280);
    step();

    // Reset in the middle of MUL aborts the operation
    a     = 16'h7FFF;
    b     = 16'h7FFF;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (7) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("t5_busy", 32'(busy), 32'h0);
    check("t5_done", 32'(done), 32'h0);
    check("t5_result", 32'(result), 32'h0);
    check("t5_sat", 32'(sat), 32'h0);
    dones = 0;
    repeat (30) begin
      step();
      if (done) dones++;
    end
    check("t5_no_done", 32'(dones), 32'h0);
    run_op(16'h0180, 16'h0200, edges, b0, bprev, bdone);
    check("t5_fresh_latency", 32'(edges), 32'd18);
    check("t5_fresh_result", 32'(result), 32'h0300);

    // Random operands against the reference model
    for (int i = 0; i < 2000; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      ref_mul(ra, rb, er, es);
      run_op(ra, rb, edges, b0, bprev, bdone);
      check("rand_result", 32'(result), 32'(er));
      check("rand_sat", 32'(sat), 32'(es));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
